lsu_byte_seq: RTL and testbench
===============================

# lsu_byte_seq

Load/store sequencer sitting between the CPU memory stage and the 1536×8 byte-wide data RAM (3 × 512×8 banks, positive-edge read and write). It accepts one byte/half/word load or store per request, splits it into single-byte RAM accesses, and assembles loads with sign- or zero-extension. It drives the RAM's read and write ports as their sole initiator. It checks alignment and range, and returns exactly one response per accepted request.

## Interface

Parameters:

- MEM_BYTES, 1536: addressable bytes; bytes at MEM_BYTES and above are out of range.
- ADDR_W, 11: byte address width.

Ports:

- CLK  in  1  single clock. Also drives RAM RCLK/WCLK.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on this edge when both valid and ready are high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when set, else sign-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, little-endian; byte i comes from bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_err  out  1  valid with rsp_valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- RAM_RE, RAM_RADDR[ADDR_W-1:0]  out  read port.
- RAM_RDATA  in  8  read data.
- RAM_WE, RAM_WADDR[ADDR_W-1:0], RAM_WDATA[7:0]  out  write port.

## Operation

- States: IDLE, RD_ISSUE, RD_CAP, WR, RESP.
- **IDLE**
  - req_ready is 1 only in IDLE.
  - On accept, latch we/size/unsigned/addr/wdata and clear byte index i.
  - If the request is legal, go to RD_ISSUE (load) or WR (store).
  - If it is an error, go to RESP with err set.
- **Error conditions**
  - size 11.
  - half with addr[0] = 1.
  - word with addr[1:0] ≠ 0.
  - addr + nbytes − 1 ≥ MEM_BYTES.
  - An error request performs no RAM access.
- **RD_ISSUE**
  - Drive RAM_RE = 1, RAM_RADDR = addr + i.
  - Next state: RD_CAP.
- **RD_CAP**
  - Keep RAM_RE = 1 and RAM_RADDR unchanged. The RAM output mux selects its bank from the *current* RADDR[10:9] and RE.
  - Capture RAM_RDATA into byte i at the end of the cycle.
  - If i = nbytes − 1, go to RESP. Otherwise increment i and go to RD_ISSUE.
  - Byte reads never overlap.
- **WR**
  - Drive RAM_WE = 1, RAM_WADDR = addr + i, RAM_WDATA = wdata byte i.
  - If i = nbytes − 1, go to RESP; otherwise increment i.
- **RESP**
  - Drive rsp_valid = 1 and rsp_err.
  - rsp_rdata carries the loaded bytes: sign-extended from bit 7/15, or zero-extended when req_unsigned is set. It is 0 for stores and errors.
  - Next state: IDLE.
- **Idle outputs:** RAM_RE and RAM_WE are 0 outside the states above; addresses and write data are 0 when their enable is 0.
- **Banks:** aligned accesses never straddle a 512-byte bank boundary, so no bank-crossing handling is required.

## Timing

- Reset values: all outputs 0, except req_ready = 1 after reset is released (state IDLE).
- Accept at edge E0. Cycle n means the cycle after edge En−1.
- Loads (nbytes = 1/2/4): issue/capture pairs occupy cycles 1 to 2·nbytes, and rsp_valid is high in cycle 2·nbytes + 1.
  - lb: response in cycle 3.
  - lh: response in cycle 5.
  - lw: response in cycle 9.
- Stores: writes occupy cycles 1 to nbytes, and rsp_valid is high in cycle nbytes + 1.
  - sw: response in cycle 5.
- Errors: rsp_valid in cycle 1.
- The next request can be accepted in the cycle after RESP. req_valid while busy is ignored and not queued.
- Reset asserted mid-operation:
  - The state returns to IDLE immediately and all outputs go to 0.
  - A partially written store is not rolled back.
  - No response is issued for the aborted request.

## Structure

- Shared package mem_pkg holds:
  - size_t enum (SIZE_B, SIZE_H, SIZE_W).
  - MEM_BYTES constant.
  - lsu_state_t enum.
  - nbytes(size) function.
- Sub-module load_extend: combinational (rdata_raw[31:0], size, unsigned) → rsp_rdata. It is reused by the fetch path.
- The sequencer itself is a single always_ff state register plus an always_comb output/next-state block.

## Test plan

- sw 0xDEADBEEF @0x004, then lw @0x004 → store writes bytes EF, BE, AD, DE at 4–7 in cycles 1–4 with rsp in cycle 5; load returns rsp_rdata = 0xDEADBEEF, err = 0, in cycle 9.
- sb 0x80 @0x201 (bank 1), then lb and lbu @0x201 → 0xFFFFFF80 and 0x00000080; RAM_RADDR[10:9] = 01 and RAM_RE stay stable across each issue/capture pair.
- sh 0x8001 @0x5FE, then lh → 0xFFFF8001; lhu → 0x00008001 (last bank, top address).
- lw @0x002, lh @0x003, lw @0x600, size 11 @0x000 → each gives rsp_err = 1 in cycle 1, rsp_rdata = 0, no RAM_RE/RAM_WE pulse.
- req_valid held high during an lw → req_ready stays 0 in cycles 1–9; the second request is accepted at the edge ending cycle 10.
- RST_N low in cycle 3 of an sw @0x008 → outputs 0 immediately; bytes 8–9 written, 10–11 unchanged; no rsp_valid; req_ready = 1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide data RAM and its load/store sequencer.
//   size_t      : access size encoding (2'b11 is illegal and has no member)
//   lsu_state_t : sequencer FSM states
//   MEM_BYTES   : number of addressable RAM bytes
//   nbytes()    : byte count for a size encoding
package mem_pkg;

    localparam int unsigned MEM_BYTES = 1536;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    // The illegal encoding maps to 1 so range arithmetic stays well defined;
    // such requests are rejected before any byte is moved.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  nbytes = 3'd1;
            SIZE_H:  nbytes = 3'd2;
            SIZE_W:  nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension, shared by the LSU and the fetch path.
//   rdata_raw_i : assembled little-endian bytes (unused upper bytes ignored)
//   size_i      : byte / half / word
//   unsigned_i  : 1 = zero-extend, 0 = sign-extend
//   rdata_o     : extended 32-bit result
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = rdata_raw_i;
        case (size_i)
            SIZE_B:  rdata_o = {{24{~unsigned_i & rdata_raw_i[7]}},  rdata_raw_i[7:0]};
            SIZE_H:  rdata_o = {{16{~unsigned_i & rdata_raw_i[15]}}, rdata_raw_i[15:0]};
            default: rdata_o = rdata_raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer between the CPU memory stage and the byte-wide RAM.
// Splits byte/half/word requests into single-byte RAM accesses, assembles
// and extends loads, rejects misaligned/out-of-range/illegal-size requests,
// and returns exactly one response per accepted request.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   req_*                 : request handshake and payload (valid/ready)
//   rsp_valid/err/rdata   : one-cycle response pulse
//   RAM_RE/RADDR/RDATA    : RAM read port (registered read, 1-cycle latency)
//   RAM_WE/WADDR/WDATA    : RAM write port
module lsu_byte_seq
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = mem_pkg::MEM_BYTES,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              RAM_RE,
    output logic [ADDR_W-1:0] RAM_RADDR,
    input  logic [7:0]        RAM_RDATA,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic [7:0]        RAM_WDATA
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic [31:0]       rbuf_q, rbuf_d;

    logic              ready_c;
    logic              req_illegal;
    logic              misaligned;
    logic [ADDR_W:0]   req_last_addr;
    logic [1:0]        last_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       ext_rdata;

    // Request legality, evaluated on the live request inputs.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = req_addr[0];
            SIZE_W:  misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        req_last_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes(req_size))
                        - (ADDR_W+1)'(1);
        req_illegal   = misaligned || (32'(req_last_addr) >= MEM_BYTES);
    end

    assign last_idx = 2'(nbytes(size_q) - 3'd1);
    assign cur_addr = addr_q + ADDR_W'(idx_q);

    load_extend u_load_extend (
        .rdata_raw_i (rbuf_q),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .rdata_o     (ext_rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rbuf_d    = rbuf_q;
        ready_c   = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        RAM_RE    = 1'b0;
        RAM_RADDR = '0;
        RAM_WE    = 1'b0;
        RAM_WADDR = '0;
        RAM_WDATA = '0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                    rbuf_d  = '0;
                    err_d   = req_illegal;
                    if (req_illegal) begin
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end

            ST_RD_ISSUE: begin
                RAM_RE    = 1'b1;
                RAM_RADDR = cur_addr;
                state_d   = ST_RD_CAP;
            end

            // RE/RADDR held so the RAM's bank mux keeps selecting this byte.
            ST_RD_CAP: begin
                RAM_RE    = 1'b1;
                RAM_RADDR = cur_addr;
                rbuf_d[{idx_q, 3'b000} +: 8] = RAM_RDATA;
                if (idx_q == last_idx) begin
                    state_d = ST_RESP;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_RD_ISSUE;
                end
            end

            ST_WR: begin
                RAM_WE    = 1'b1;
                RAM_WADDR = cur_addr;
                RAM_WDATA = wdata_q[{idx_q, 3'b000} +: 8];
                if (idx_q == last_idx) begin
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? '0 : ext_rdata;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Ready must read 0 while reset is held, even though the state is IDLE.
    assign req_ready = ready_c & RST_N;

endmodule

// File: tb/tb_lsu_byte_seq.sv
module tb_lsu_byte_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        RAM_RE;
    logic [10:0] RAM_RADDR;
    logic [7:0]  RAM_RDATA;
    logic        RAM_WE;
    logic [10:0] RAM_WADDR;
    logic [7:0]  RAM_WDATA;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    lsu_byte_seq #(.MEM_BYTES(1536), .ADDR_W(11)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .RAM_RE       (RAM_RE),
        .RAM_RADDR    (RAM_RADDR),
        .RAM_RDATA    (RAM_RDATA),
        .RAM_WE       (RAM_WE),
        .RAM_WADDR    (RAM_WADDR),
        .RAM_WDATA    (RAM_WDATA)
    );

    // RAM model: three 512x8 banks, registered read per bank, output mux
    // driven by the current RADDR[10:9] and RE.
    logic [7:0] mem [0:1535];
    logic [7:0] bank_q [0:2];

    always @(posedge CLK) begin
        if (RAM_WE && RAM_WADDR < 11'd1536) mem[RAM_WADDR] <= RAM_WDATA;
        if (RAM_RE && RAM_RADDR[10:9] != 2'b11) bank_q[RAM_RADDR[10:9]] <= mem[RAM_RADDR];
    end

    assign RAM_RDATA = (RAM_RE && RAM_RADDR[10:9] != 2'b11) ? bank_q[RAM_RADDR[10:9]] : 8'h00;

    // Per-cycle observations of the last request (index = cycle number).
    logic        obs_re    [0:20];
    logic [10:0] obs_raddr [0:20];
    logic        obs_we    [0:20];
    logic [10:0] obs_waddr [0:20];
    logic [7:0]  obs_wdata [0:20];
    int          n_re, n_we;
    logic        ready_at_issue;

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [10:0] addr, input logic [31:0] wdata,
                           output int rcyc, output logic rerr, output logic [31:0] rdata);
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        ready_at_issue = req_ready;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        rcyc = 0; rerr = 1'b0; rdata = '0; n_re = 0; n_we = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            obs_re[n] = RAM_RE;  obs_raddr[n] = RAM_RADDR;
            obs_we[n] = RAM_WE;  obs_waddr[n] = RAM_WADDR; obs_wdata[n] = RAM_WDATA;
            if (RAM_RE) n_re++;
            if (RAM_WE) n_we++;
            if (rsp_valid) begin
                rcyc = n; rerr = rsp_err; rdata = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, RAM_RE, RAM_RADDR, RAM_WE, RAM_WADDR, RAM_WDATA} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b rsp_valid=%b re=%b we=%b rdata=%h, want all 0",
                     req_ready, rsp_valid, RAM_RE, RAM_WE, rsp_rdata);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        int c; logic e; logic [31:0] d;
        logic [31:0] w = 32'hDEADBEEF;
        run_req(1'b1, 2'b10, 1'b0, 11'h004, w, c, e, d);
        tests_run++;
        if (ready_at_issue !== 1'b1) begin
            tests_failed++; $display("FAIL sw_ready: got %b want 1", ready_at_issue);
        end
        tests_run++;
        if (c != 5) begin
            tests_failed++; $display("FAIL sw_rsp_cycle: got %0d want 5", c);
        end
        tests_run++;
        if (e !== 1'b0 || d !== 32'h0) begin
            tests_failed++; $display("FAIL sw_rsp: got err=%b rdata=%h want err=0 rdata=0", e, d);
        end
        for (int k = 1; k <= 4; k++) begin
            tests_run++;
            if (obs_we[k] !== 1'b1 || obs_waddr[k] !== 11'(3 + k) || obs_wdata[k] !== w[8*(k-1) +: 8]) begin
                tests_failed++;
                $display("FAIL sw_write_c%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         k, obs_we[k], obs_waddr[k], obs_wdata[k], 11'(3 + k), w[8*(k-1) +: 8]);
            end
        end
        run_req(1'b0, 2'b10, 1'b0, 11'h004, 32'h0, c, e, d);
        tests_run++;
        if (c != 9 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_readback: got cyc=%0d err=%b rdata=%h want cyc=9 err=0 rdata=deadbeef", c, e, d);
        end
    endtask

    task automatic test_bank1_byte();
        int c; logic e; logic [31:0] d;
        run_req(1'b1, 2'b00, 1'b0, 11'h201, 32'h0000_0080, c, e, d);
        tests_run++;
        if (c != 2 || e !== 1'b0) begin
            tests_failed++; $display("FAIL sb_rsp: got cyc=%0d err=%b want cyc=2 err=0", c, e);
        end
        run_req(1'b0, 2'b00, 1'b0, 11'h201, 32'h0, c, e, d);
        tests_run++;
        if (c != 3 || d !== 32'hFFFFFF80) begin
            tests_failed++; $display("FAIL lb_bank1: got cyc=%0d rdata=%h want cyc=3 rdata=ffffff80", c, d);
        end
        tests_run++;
        if (obs_re[1] !== 1'b1 || obs_re[2] !== 1'b1 || obs_raddr[1] !== 11'h201 ||
            obs_raddr[2] !== 11'h201 || obs_raddr[2][10:9] !== 2'b01) begin
            tests_failed++;
            $display("FAIL lb_re_stable: got re=%b%b raddr=%h,%h want re=11 raddr=201,201",
                     obs_re[1], obs_re[2], obs_raddr[1], obs_raddr[2]);
        end
        run_req(1'b0, 2'b00, 1'b1, 11'h201, 32'h0, c, e, d);
        tests_run++;
        if (c != 3 || d !== 32'h00000080) begin
            tests_failed++; $display("FAIL lbu_bank1: got cyc=%0d rdata=%h want cyc=3 rdata=00000080", c, d);
        end
    endtask

    task automatic test_half_top();
        int c; logic e; logic [31:0] d;
        run_req(1'b1, 2'b01, 1'b0, 11'h5FE, 32'h0000_8001, c, e, d);
        tests_run++;
        if (c != 3 || e !== 1'b0 || obs_waddr[2] !== 11'h5FF || obs_wdata[2] !== 8'h80) begin
            tests_failed++;
            $display("FAIL sh_top: got cyc=%0d err=%b waddr2=%h wdata2=%h want cyc=3 err=0 waddr2=5ff wdata2=80",
                     c, e, obs_waddr[2], obs_wdata[2]);
        end
        run_req(1'b0, 2'b01, 1'b0, 11'h5FE, 32'h0, c, e, d);
        tests_run++;
        if (c != 5 || e !== 1'b0 || d !== 32'hFFFF8001) begin
            tests_failed++; $display("FAIL lh_top: got cyc=%0d err=%b rdata=%h want cyc=5 err=0 rdata=ffff8001", c, e, d);
        end
        tests_run++;
        if (obs_raddr[1] !== 11'h5FE || obs_raddr[3] !== 11'h5FF) begin
            tests_failed++; $display("FAIL lh_addrs: got %h,%h want 5fe,5ff", obs_raddr[1], obs_raddr[3]);
        end
        run_req(1'b0, 2'b01, 1'b1, 11'h5FE, 32'h0, c, e, d);
        tests_run++;
        if (c != 5 || d !== 32'h00008001) begin
            tests_failed++; $display("FAIL lhu_top: got cyc=%0d rdata=%h want cyc=5 rdata=00008001", c, d);
        end
    endtask

    task automatic test_errors();
        int c; logic e; logic [31:0] d;
        logic        t_we   [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  t_size [0:5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [10:0] t_addr [0:5] = '{11'h002, 11'h003, 11'h600, 11'h000, 11'h002, 11'h600};
        for (int k = 0; k < 6; k++) begin
            run_req(t_we[k], t_size[k], 1'b0, t_addr[k], 32'hFFFF_FFFF, c, e, d);
            tests_run++;
            if (c != 1 || e !== 1'b1 || d !== 32'h0 || n_re != 0 || n_we != 0) begin
                tests_failed++;
                $display("FAIL err_case%0d: got cyc=%0d err=%b rdata=%h re=%0d we=%0d want cyc=1 err=1 rdata=0 re=0 we=0",
                         k, c, e, d, n_re, n_we);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ready_seen = 0;
        int rsp_at = 0;
        int c2 = 0;
        logic [31:0] d1 = '0;
        logic [31:0] d2 = '0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 11'h004; req_wdata = '0;
        @(posedge CLK);
        #1 req_size = 2'b00;   // second request: lb @0x004, held while busy
        for (int n = 1; n <= 9; n++) begin
            @(negedge CLK);
            if (req_ready) ready_seen++;
            if (rsp_valid && rsp_at == 0) begin
                rsp_at = n; d1 = rsp_rdata;
            end
        end
        tests_run++;
        if (ready_seen != 0) begin
            tests_failed++; $display("FAIL busy_ready: got %0d ready cycles want 0", ready_seen);
        end
        tests_run++;
        if (rsp_at != 9 || d1 !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL busy_lw: got cyc=%0d rdata=%h want cyc=9 rdata=deadbeef", rsp_at, d1);
        end
        @(negedge CLK);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL cycle10_ready: got %b want 1", req_ready);
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                c2 = n; d2 = rsp_rdata;
                break;
            end
        end
        tests_run++;
        if (c2 != 3 || d2 !== 32'hFFFFFFEF) begin
            tests_failed++; $display("FAIL second_lb: got cyc=%0d rdata=%h want cyc=3 rdata=ffffffef", c2, d2);
        end
    endtask

    task automatic test_reset_mid();
        int c; logic e; logic [31:0] d;
        int rsp_seen = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 11'h008; req_wdata = 32'h11223344;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b0;       // now in cycle 3, before the third byte is written
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, RAM_RE, RAM_RADDR, RAM_WE, RAM_WADDR, RAM_WDATA} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got ready=%b rsp_valid=%b we=%b waddr=%h wdata=%h want all 0",
                     req_ready, rsp_valid, RAM_WE, RAM_WADDR, RAM_WDATA);
        end
        repeat (2) begin
            @(negedge CLK);
            if (rsp_valid) rsp_seen++;
        end
        RST_N = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        repeat (2) begin
            @(negedge CLK);
            if (rsp_valid) rsp_seen++;
        end
        tests_run++;
        if (rsp_seen != 0) begin
            tests_failed++; $display("FAIL midreset_no_rsp: got %0d pulses want 0", rsp_seen);
        end
        tests_run++;
        if (mem[8] !== 8'h44 || mem[9] !== 8'h33 || mem[10] !== 8'hA5 || mem[11] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL midreset_mem: got %h %h %h %h want 44 33 a5 a5", mem[8], mem[9], mem[10], mem[11]);
        end
        run_req(1'b0, 2'b10, 1'b0, 11'h008, 32'h0, c, e, d);
        tests_run++;
        if (c != 9 || e !== 1'b0 || d !== 32'hA5A53344) begin
            tests_failed++; $display("FAIL midreset_lw: got cyc=%0d err=%b rdata=%h want cyc=9 err=0 rdata=a5a53344", c, e, d);
        end
    endtask

    initial begin
        for (int i = 0; i < 1536; i++) mem[i] = 8'hA5;
        for (int i = 0; i < 3; i++) bank_q[i] = 8'h00;
        test_reset();
        test_word();
        test_bank1_byte();
        test_half_top();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
